// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op/state encodings and helpers for the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] C_OP_MULT  = 2'b00;
  localparam logic [1:0] C_OP_MULTU = 2'b01;
  localparam logic [1:0] C_OP_DIV   = 2'b10;
  localparam logic [1:0] C_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    OP_MULT  = C_OP_MULT,
    OP_MULTU = C_OP_MULTU,
    OP_DIV   = C_OP_DIV,
    OP_DIVU  = C_OP_DIVU
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Brief    : One combinational radix-2 step: shift-add multiply or restoring
//            shift-subtract divide on an unsigned {hi,lo} accumulator pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  assign w_sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand_b} : '0);
  assign w_shifted = {hi_in, lo_in[XLEN-1]};
  // Remainder stays below the divisor, so one extra bit holds the shifted value.
  assign w_diff    = w_shifted - {1'b0, operand_b};

  always_comb begin
    hi_out = w_sum[XLEN:1];
    lo_out = {w_sum[0], lo_in[XLEN-1:1]};
    if (is_div) begin
      if (!w_diff[XLEN]) begin
        hi_out = w_diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = w_shifted[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, pipeline
//            stall generation, flush and MTHI/MTLO support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ip_start,
  input  logic [1:0]      ip_op,
  input  logic [XLEN-1:0] ip_rs,
  input  logic [XLEN-1:0] ip_rt,
  input  logic            ip_flush,
  input  logic            ip_mthi,
  input  logic            ip_mtlo,
  input  logic            ip_read_req,
  output logic [XLEN-1:0] op_hi,
  output logic [XLEN-1:0] op_lo,
  output logic            op_busy,
  output logic            op_done,
  output logic            op_div_by_zero,
  output logic            op_stall
);

  localparam int N     = XLEN / STEPS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  muldiv_state_e     r_state;
  muldiv_state_e     w_state_nx;
  logic [CNT_W-1:0]  r_count;
  logic              r_is_div;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_mag_a;
  logic [XLEN-1:0]   r_mag_b;
  logic [XLEN-1:0]   r_acc_hi;
  logic [XLEN-1:0]   r_acc_lo;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;
  logic              r_dbz_flag;

  logic              w_idle;
  logic              w_accept;
  logic              w_mt_ok;
  logic              w_sign_rs;
  logic              w_sign_rt;
  logic [XLEN-1:0]   w_mag_rs;
  logic [XLEN-1:0]   w_mag_rt;
  logic              w_is_dbz;
  logic              w_last;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & ip_start & ~ip_flush;
  assign w_mt_ok   = w_idle & ~ip_start;
  assign w_sign_rs = op_is_signed(ip_op) & op_is_div(ip_op) ? ip_rs[XLEN-1] :
                     op_is_signed(ip_op) & ip_rs[XLEN-1];
  assign w_sign_rt = op_is_signed(ip_op) & ip_rt[XLEN-1];
  // Magnitude of the most negative value is itself read as unsigned.
  assign w_mag_rs  = w_sign_rs ? (~ip_rs + 1'b1) : ip_rs;
  assign w_mag_rt  = w_sign_rt ? (~ip_rt + 1'b1) : ip_rt;
  assign w_is_dbz  = r_is_div & (r_mag_b == '0);
  assign w_last    = (r_count == CNT_W'(N - 1));

  // ---------------------------------------------------------------------------
  // Iteration chain
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_hi_chain [STEPS+1];
  logic [XLEN-1:0] w_lo_chain [STEPS+1];

  assign w_hi_chain[0] = r_acc_hi;
  assign w_lo_chain[0] = r_acc_lo;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    muldiv_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div    (r_is_div),
      .hi_in     (w_hi_chain[gi]),
      .lo_in     (w_lo_chain[gi]),
      .operand_b (r_mag_b),
      .hi_out    (w_hi_chain[gi+1]),
      .lo_out    (w_lo_chain[gi+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Sign correction of the unsigned result
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_rs_orig;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~r_acc_lo + 1'b1) : r_acc_lo;
  assign w_rem_fix  = r_sign_a ? (~r_acc_hi + 1'b1) : r_acc_hi;
  assign w_rs_orig  = r_sign_a ? (~r_mag_a + 1'b1) : r_mag_a;

  always_comb begin
    w_res_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_res_lo = w_prod_fix[XLEN-1:0];
    if (w_is_dbz) begin
      w_res_hi = w_rs_orig;
      w_res_lo = '1;
    end else if (r_is_div) begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    op_busy    = (r_state != ST_IDLE);
    op_stall   = 1'b0;
    if (op_busy) begin
      op_stall = ip_start | ip_read_req | ip_mthi | ip_mtlo;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = ST_PREP;
        end
      end
      ST_PREP: begin
        w_state_nx = w_is_dbz ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nx = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    if (ip_flush && (r_state != ST_IDLE)) begin
      w_state_nx = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div   <= op_is_div(ip_op);
            r_sign_a   <= w_sign_rs;
            r_sign_b   <= w_sign_rt;
            r_mag_a    <= w_mag_rs;
            r_mag_b    <= w_mag_rt;
            r_dbz_flag <= 1'b0;
          end else if (w_mt_ok) begin
            if (ip_mthi) begin
              r_hi <= ip_rs;
            end
            if (ip_mtlo) begin
              r_lo <= ip_rs;
            end
          end
        end
        ST_PREP: begin
          r_acc_hi <= '0;
          r_acc_lo <= r_mag_a;
          r_count  <= '0;
        end
        ST_RUN: begin
          r_acc_hi <= w_hi_chain[STEPS];
          r_acc_lo <= w_lo_chain[STEPS];
          r_count  <= r_count + CNT_W'(1);
        end
        ST_FIX: begin
          if (!ip_flush) begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_done     <= 1'b1;
            r_dbz_flag <= w_is_dbz;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign op_hi          = r_hi;
  assign op_lo          = r_lo;
  assign op_done        = r_done;
  assign op_div_by_zero = r_dbz_flag;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench driving a STEPS=1 and a STEPS=4 instance in
//            parallel against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ip_start = 1'b0;
  logic [1:0]      ip_op = 2'b00;
  logic [XLEN-1:0] ip_rs = '0;
  logic [XLEN-1:0] ip_rt = '0;
  logic            ip_flush = 1'b0;
  logic            ip_mthi = 1'b0;
  logic            ip_mtlo = 1'b0;
  logic            ip_read_req = 1'b0;

  logic [XLEN-1:0] hi1, lo1, hi4, lo4;
  logic            busy1, done1, dbz1, stall1;
  logic            busy4, done4, dbz4, stall4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_hi [2];
  logic [XLEN-1:0] m_lo [2];

  muldiv_unit #(.XLEN(XLEN), .STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ip_start(ip_start), .ip_op(ip_op),
    .ip_rs(ip_rs), .ip_rt(ip_rt), .ip_flush(ip_flush), .ip_mthi(ip_mthi),
    .ip_mtlo(ip_mtlo), .ip_read_req(ip_read_req), .op_hi(hi1), .op_lo(lo1),
    .op_busy(busy1), .op_done(done1), .op_div_by_zero(dbz1), .op_stall(stall1)
  );

  muldiv_unit #(.XLEN(XLEN), .STEPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ip_start(ip_start), .ip_op(ip_op),
    .ip_rs(ip_rs), .ip_rt(ip_rt), .ip_flush(ip_flush), .ip_mthi(ip_mthi),
    .ip_mtlo(ip_mtlo), .ip_read_req(ip_read_req), .op_hi(hi4), .op_lo(lo4),
    .op_busy(busy4), .op_done(done4), .op_div_by_zero(dbz4), .op_stall(stall4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} straight from the architectural definition.
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, 64'(sp)};
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, up};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100 && (busy1 || busy4); i++) begin
      @(posedge clk); #1;
    end
    check("wait_idle", {62'd0, busy1, busy4}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [64:0] r;
    int          lat1;
    int          lat4;
    int          exp1;
    int          exp4;
    bit          partial;
    lat1    = -1;
    lat4    = -1;
    partial = 1'b0;
    wait_idle();
    r     = ref_op(op, a, b);
    exp1  = r[64] ? 2 : 34;
    exp4  = r[64] ? 2 : 10;
    ip_op = op; ip_rs = a; ip_rt = b; ip_start = 1'b1;
    @(posedge clk); #1;
    ip_start = 1'b0;
    for (int c = 1; c <= 60 && (lat1 < 0 || lat4 < 0); c++) begin
      @(posedge clk); #1;
      if (lat1 < 0) begin
        if (done1) lat1 = c;
        else if ({hi1, lo1} !== {m_hi[0], m_lo[0]}) partial = 1'b1;
      end
      if (lat4 < 0) begin
        if (done4) lat4 = c;
        else if ({hi4, lo4} !== {m_hi[1], m_lo[1]}) partial = 1'b1;
      end
    end
    check({tag, "_lat1"}, 64'(lat1), 64'(exp1));
    check({tag, "_lat4"}, 64'(lat4), 64'(exp4));
    check({tag, "_hilo1"}, {hi1, lo1}, r[63:0]);
    check({tag, "_hilo4"}, {hi4, lo4}, r[63:0]);
    check({tag, "_dbz"}, {62'd0, dbz1, dbz4}, {62'd0, r[64], r[64]});
    check({tag, "_nopartial"}, 64'(partial), 64'd0);
    m_hi[0] = r[63:32]; m_lo[0] = r[31:0];
    m_hi[1] = r[63:32]; m_lo[1] = r[31:0];
  endtask

  initial begin
    logic [64:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] v;
    int          cyc;
    int          bad;
    bit          got1;
    bit          seen1;
    bit          seen4;
    bit          hsel;

    for (int k = 0; k < 2; k++) begin
      m_hi[k] = '0;
      m_lo[k] = '0;
    end

    #3;
    check("reset_hilo1", {hi1, lo1}, 64'd0);
    check("reset_flags", {56'd0, busy1, done1, dbz1, stall1, busy4, done4, dbz4, stall4}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu_small", 2'b01, 32'd6, 32'd7);

    // Stall behaviour while busy, and visibility of the result right after.
    wait_idle();
    a = $urandom; b = $urandom;
    r = ref_op(2'b00, a, b);
    ip_op = 2'b00; ip_rs = a; ip_rt = b; ip_start = 1'b1;
    @(posedge clk); #1;
    ip_start = 1'b0;
    cyc = 0; bad = 0; got1 = 1'b0;
    while (!got1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done4) begin
        m_hi[1] = r[63:32]; m_lo[1] = r[31:0];
      end
      if (done1) begin
        got1 = 1'b1;
      end else begin
        if (cyc >= 3) ip_read_req = 1'b1;
        if (cyc == 5) begin
          ip_start = 1'b1; ip_op = 2'b11; ip_rs = 32'd99; ip_rt = 32'd3;
        end else begin
          ip_start = 1'b0;
        end
        #1;
        if (cyc == 5) check("stall_start_busy", {62'd0, stall1, busy1}, 64'd3);
        if (cyc >= 3 && !stall1) bad++;
      end
    end
    ip_start = 1'b0;
    check("stall_held", 64'(bad), 64'd0);
    check("stall_lat", 64'(cyc), 64'd34);
    check("stall_release", {63'd0, stall1}, 64'd0);
    check("stall_read_hilo1", {hi1, lo1}, r[63:0]);
    check("stall_hilo4", {hi4, lo4}, r[63:0]);
    ip_read_req = 1'b0;
    m_hi[0] = r[63:32]; m_lo[0] = r[31:0];

    // MTHI preload then flush a divide mid-run.
    wait_idle();
    ip_mthi = 1'b1; ip_rs = 32'h1234;
    @(posedge clk); #1;
    ip_mthi = 1'b0;
    check("mthi", {hi1, hi4}, {32'h1234, 32'h1234});
    m_hi[0] = 32'h1234; m_hi[1] = 32'h1234;
    a = $urandom; b = $urandom | 32'd1;
    r = ref_op(2'b10, a, b);
    ip_op = 2'b10; ip_rs = a; ip_rt = b; ip_start = 1'b1;
    @(posedge clk); #1;
    ip_start = 1'b0;
    seen1 = 1'b0; seen4 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done1) seen1 = 1'b1;
      if (done4) begin
        seen4 = 1'b1; m_hi[1] = r[63:32]; m_lo[1] = r[31:0];
      end
      ip_flush = (c == 11);
      if (c == 12) check("flush_busy", {63'd0, busy1}, 64'd0);
    end
    ip_flush = 1'b0;
    check("flush_no_done", {62'd0, seen1, seen4}, 64'd1);
    check("flush_hilo1", {hi1, lo1}, {m_hi[0], m_lo[0]});
    check("flush_hilo4", {hi4, lo4}, {m_hi[1], m_lo[1]});

    // Asynchronous reset in the middle of RUN.
    wait_idle();
    ip_op = 2'b01; ip_rs = $urandom; ip_rt = $urandom; ip_start = 1'b1;
    @(posedge clk); #1;
    ip_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; ip_read_req = 1'b1;
    #1;
    check("rst_mid_hilo", {hi1 | hi4, lo1 | lo4}, 64'd0);
    check("rst_mid_flags", {56'd0, busy1, done1, dbz1, stall1, busy4, done4, dbz4, stall4}, 64'd0);
    ip_read_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_hi[k] = '0;
      m_lo[k] = '0;
    end

    // Randomised operations interleaved with MTHI/MTLO writes.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        v = $urandom; hsel = 1'($urandom_range(0, 1));
        ip_rs = v; ip_mthi = hsel; ip_mtlo = ~hsel;
        @(posedge clk); #1;
        ip_mthi = 1'b0; ip_mtlo = 1'b0;
        for (int k = 0; k < 2; k++) begin
          if (hsel) m_hi[k] = v;
          else      m_lo[k] = v;
        end
        check("rand_mt", {hi1 ^ hi4, lo1}, {32'd0, m_lo[0]});
      end
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op("rand", 2'($urandom_range(0, 3)), a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
